dma_channel_regfile: RTL and testbench
======================================

Name: dma_channel_regfile

Overview:
- Parametrised per-channel address and word-count register file for the DMA controller. It generalises channel count, address width and data width.
- Replaces the fixed 4-channel, 16-bit, single-flip-flop scheme with an N-byte programming pointer.
- Adds per-channel autoinitialize, address increment/decrement, and terminal-count (TC) detection with sticky status.
- Sits between the CPU-side register decoder and the transfer-timing FSM.

Parameters:
- CHANNELS, 4, number of DMA channels (>=1).
- ADDRESSWIDTH, 16, width of address and word-count registers; must be a multiple of DATAWIDTH.
- DATAWIDTH, 8, CPU data bus width.
- Derived locals: NB = ADDRESSWIDTH/DATAWIDTH (bytes per register); CW = max(1, $clog2(CHANNELS)); PW = max(1, $clog2(NB)).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- progEn  in  1  program condition (controller idle); gates all CPU accesses.
- wrEn  in  1  CPU write strobe for the register selected by regSel/chSel.
- rdEn  in  1  CPU read strobe for the current register selected by regSel/chSel.
- regSel  in  1  0 = address register, 1 = word-count register.
- chSel  in  CW  channel for program accesses and mode writes.
- wrData  in  DATAWIDTH  byte written.
- rdData  out  DATAWIDTH  registered read byte.
- clearPtr  in  1  clear the byte pointer.
- modeWr  in  1  write mode bits of channel chSel.
- modeData  in  2  bit0 = autoinit, bit1 = decrement address.
- xferStart  in  1  load temporary registers from current registers of xferCh.
- xferCh  in  CW  active transfer channel.
- xferStep  in  1  advance one word.
- xferEnd  in  1  write back temporary registers.
- addrOut  out  ADDRESSWIDTH  temporary address register.
- tc  out  1  one-cycle TC pulse.
- statusRd  in  1  read-and-clear of tcStatus.
- tcStatus  out  CHANNELS  sticky per-channel TC flags.
- bytePtr  out  PW  current byte pointer.

Behaviour:
- Reset (async): all base, current and temporary registers, mode bits, bytePtr, rdData, tc and tcStatus go to 0.

Programming (accepted only when progEn=1):
- wrEn writes wrData into byte [bytePtr] of both base and current of (regSel, chSel).
- rdEn loads rdData with byte [bytePtr] of current of (regSel, chSel). Latency is 1 cycle; rdData holds otherwise.
- Each accepted wrEn or rdEn advances bytePtr modulo NB. If wrEn and rdEn are both high, the write wins and the pointer advances once.
- clearPtr forces bytePtr=0 and overrides any advance in the same cycle.
- modeWr updates the mode of chSel. It is accepted regardless of progEn.

Transfer (accepted only when progEn=0; CPU strobes are ignored in this case):
- xferStart copies current address and current count of xferCh into tempAddr and tempCnt; the channel is latched.
- xferStep updates the temporaries:
  - tempAddr ±1 (decrement if mode bit1), wrapping modulo 2^ADDRESSWIDTH.
  - tempCnt −1, wrapping.
  - If tempCnt was 0 before the step, tc=1 next cycle and tcStatus[ch] is set.
- xferEnd writes back to current:
  - If TC has occurred since xferStart and autoinit=1, current is reloaded from base.
  - Otherwise current takes the temporary values.
- xferStep and xferEnd in the same cycle: write-back uses the post-step values, and a TC on that step is honoured.
- xferStart together with step/end in the same cycle: xferStart wins and the others are dropped.

Status and outputs:
- statusRd clears tcStatus. A TC set in the same cycle wins (that bit stays 1).
- addrOut = tempAddr, registered.
- Reset asserted mid-transfer aborts it; no write-back occurs.

Decomposition:
- dmaRegConfigPkg holds: CHANNELS, ADDRESSWIDTH and DATAWIDTH defaults; typedef modeBits_t (packed struct {decrement, autoinit}); typedef regSel_e {ADDR_SEL, COUNT_SEL}.
- One sub-module, dma_xfer_counter, holds tempAddr/tempCnt, the inc/dec logic, TC detection and the TC-seen flag. The top level holds the register arrays, byte pointer and status.

Test Plan:
- Write 0x34 then 0x12 to channel 2 address (regSel=0) after clearPtr -> base=current=0x1234; two rdEn return rdData 0x34 then 0x12 one cycle after each strobe; bytePtr=0 afterwards.
- Channel 1: addr 0x1000, count 0x0002, mode=00; xferStart then 3 xferStep -> addrOut 0x1001, 0x1002, 0x1003; tc pulses after the third step; tcStatus=4'b0010; after xferEnd, current addr=0x1003 and count=0xFFFF.
- Same as above with mode=01 (autoinit) -> after xferEnd, current addr=0x1000 and count=0x0002; tcStatus[1]=1 until statusRd, then 0.
- Mode=10 (decrement), addr 0x0000, count 0x0000, one step -> addrOut=0xFFFF, tc pulses, wrap is verified.
- Byte pointer: write one byte, pulse clearPtr, write 0xAB -> low byte=0xAB and high byte unchanged. Write with progEn=0 -> no change and no pointer advance.
- Assert RESET asynchronously mid-transfer, between clock edges -> all outputs are 0 immediately and the current registers read 0 after release. Repeat with CHANNELS=8, ADDRESSWIDTH=24: three-byte programming round-trips 0xABCDEF.

Source files
------------

// File: rtl/dma_channel_regfile_pkg.sv
// Shared defaults and types for the DMA channel address/count register file.
package dma_channel_regfile_pkg;

  localparam int unsigned DefChannels  = 4;
  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefDataWidth = 8;

  // Packed so that modeData[1] = decrement and modeData[0] = autoinit.
  typedef struct packed {
    logic decrement;
    logic autoinit;
  } mode_bits_t;

  typedef enum logic {
    AddrSel  = 1'b0,
    CountSel = 1'b1
  } reg_sel_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dma_xfer_counter.sv
// Temporary address/count pair for the active transfer, with terminal-count detection.
module dma_xfer_counter #(
  parameter int unsigned AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          step_i,
  input  logic          decrement_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [AW-1:0] load_cnt_i,
  output logic [AW-1:0] addr_o,
  output logic [AW-1:0] next_addr_o,
  output logic [AW-1:0] next_cnt_o,
  output logic          next_seen_o,
  output logic          tc_hit_o,
  output logic          tc_o
);

  localparam logic [AW-1:0] One = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic          tc_q, tc_hit;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    seen_d = seen_q;
    tc_hit = 1'b0;
    if (start_i) begin
      addr_d = load_addr_i;
      cnt_d  = load_cnt_i;
      seen_d = 1'b0;
    end else if (step_i) begin
      addr_d = decrement_i ? (addr_q - One) : (addr_q + One);
      cnt_d  = cnt_q - One;
      tc_hit = (cnt_q == '0);
      if (tc_hit) seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      tc_q   <= tc_hit;
    end
  end

  // Write-back sees the post-step values so a same-cycle step+end is honoured.
  assign addr_o      = addr_q;
  assign next_addr_o = addr_d;
  assign next_cnt_o  = cnt_d;
  assign next_seen_o = seen_d;
  assign tc_hit_o    = tc_hit;
  assign tc_o        = tc_q;

endmodule

// File: rtl/dma_channel_regfile.sv
// Per-channel base/current address and word-count registers with a CPU byte pointer.
module dma_channel_regfile
  import dma_channel_regfile_pkg::*;
#(
  parameter int unsigned CHANNELS     = DefChannels,
  parameter int unsigned ADDRESSWIDTH = DefAddrWidth,
  parameter int unsigned DATAWIDTH    = DefDataWidth,
  localparam int unsigned NB = ADDRESSWIDTH / DATAWIDTH,
  localparam int unsigned CW = clog2_min1(CHANNELS),
  localparam int unsigned PW = clog2_min1(NB)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    progEn,
  input  logic                    wrEn,
  input  logic                    rdEn,
  input  logic                    regSel,
  input  logic [CW-1:0]           chSel,
  input  logic [DATAWIDTH-1:0]    wrData,
  output logic [DATAWIDTH-1:0]    rdData,
  input  logic                    clearPtr,
  input  logic                    modeWr,
  input  logic [1:0]              modeData,
  input  logic                    xferStart,
  input  logic [CW-1:0]           xferCh,
  input  logic                    xferStep,
  input  logic                    xferEnd,
  output logic [ADDRESSWIDTH-1:0] addrOut,
  output logic                    tc,
  input  logic                    statusRd,
  output logic [CHANNELS-1:0]     tcStatus,
  output logic [PW-1:0]           bytePtr
);

  localparam logic [PW-1:0] PtrLast = PW'(NB - 1);
  localparam logic [PW-1:0] PtrOne  = {{(PW-1){1'b0}}, 1'b1};

  logic [ADDRESSWIDTH-1:0] base_addr_q [CHANNELS];
  logic [ADDRESSWIDTH-1:0] base_addr_d [CHANNELS];
  logic [ADDRESSWIDTH-1:0] base_cnt_q  [CHANNELS];
  logic [ADDRESSWIDTH-1:0] base_cnt_d  [CHANNELS];
  logic [ADDRESSWIDTH-1:0] cur_addr_q  [CHANNELS];
  logic [ADDRESSWIDTH-1:0] cur_addr_d  [CHANNELS];
  logic [ADDRESSWIDTH-1:0] cur_cnt_q   [CHANNELS];
  logic [ADDRESSWIDTH-1:0] cur_cnt_d   [CHANNELS];
  mode_bits_t              mode_q      [CHANNELS];
  mode_bits_t              mode_d      [CHANNELS];

  logic [PW-1:0]        byte_ptr_q, byte_ptr_d, ptr_next;
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic [CHANNELS-1:0]  tc_status_q, tc_status_d;
  logic [CW-1:0]        xfer_ch_q, xfer_ch_d;
  logic [31:0]          bit_lo;

  logic cpu_wr, cpu_rd, xfer_start, xfer_step, xfer_end;
  logic [ADDRESSWIDTH-1:0] next_addr, next_cnt;
  logic next_seen, tc_hit;

  assign cpu_wr     = progEn & wrEn;
  assign cpu_rd     = progEn & rdEn & ~wrEn;
  assign xfer_start = ~progEn & xferStart;
  assign xfer_step  = ~progEn & xferStep & ~xferStart;
  assign xfer_end   = ~progEn & xferEnd & ~xferStart;
  assign bit_lo     = 32'(byte_ptr_q) * DATAWIDTH;
  assign ptr_next   = (byte_ptr_q == PtrLast) ? '0 : (byte_ptr_q + PtrOne);

  dma_xfer_counter #(
    .AW(ADDRESSWIDTH)
  ) u_xfer_counter (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .start_i     (xfer_start),
    .step_i      (xfer_step),
    .decrement_i (mode_q[xfer_ch_q].decrement),
    .load_addr_i (cur_addr_q[xferCh]),
    .load_cnt_i  (cur_cnt_q[xferCh]),
    .addr_o      (addrOut),
    .next_addr_o (next_addr),
    .next_cnt_o  (next_cnt),
    .next_seen_o (next_seen),
    .tc_hit_o    (tc_hit),
    .tc_o        (tc)
  );

  always_comb begin
    base_addr_d = base_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_addr_d  = cur_addr_q;
    cur_cnt_d   = cur_cnt_q;
    mode_d      = mode_q;
    byte_ptr_d  = byte_ptr_q;
    rd_data_d   = rd_data_q;
    tc_status_d = tc_status_q;
    xfer_ch_d   = xfer_ch_q;

    if (cpu_wr) begin
      if (reg_sel_e'(regSel) == AddrSel) begin
        base_addr_d[chSel][bit_lo +: DATAWIDTH] = wrData;
        cur_addr_d[chSel][bit_lo +: DATAWIDTH]  = wrData;
      end else begin
        base_cnt_d[chSel][bit_lo +: DATAWIDTH] = wrData;
        cur_cnt_d[chSel][bit_lo +: DATAWIDTH]  = wrData;
      end
    end else if (cpu_rd) begin
      rd_data_d = (reg_sel_e'(regSel) == AddrSel) ? cur_addr_q[chSel][bit_lo +: DATAWIDTH]
                                                 : cur_cnt_q[chSel][bit_lo +: DATAWIDTH];
    end
    if (cpu_wr || cpu_rd) byte_ptr_d = ptr_next;
    if (clearPtr) byte_ptr_d = '0;

    if (modeWr) mode_d[chSel] = mode_bits_t'(modeData);

    if (xfer_start) xfer_ch_d = xferCh;
    if (xfer_end) begin
      if (next_seen && mode_q[xfer_ch_q].autoinit) begin
        cur_addr_d[xfer_ch_q] = base_addr_q[xfer_ch_q];
        cur_cnt_d[xfer_ch_q]  = base_cnt_q[xfer_ch_q];
      end else begin
        cur_addr_d[xfer_ch_q] = next_addr;
        cur_cnt_d[xfer_ch_q]  = next_cnt;
      end
    end

    // A TC landing in the same cycle as the status read must survive the clear.
    if (statusRd) tc_status_d = '0;
    if (tc_hit) tc_status_d[xfer_ch_q] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        base_addr_q[i] <= '0;
        base_cnt_q[i]  <= '0;
        cur_addr_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
        mode_q[i]      <= '0;
      end
      byte_ptr_q  <= '0;
      rd_data_q   <= '0;
      tc_status_q <= '0;
      xfer_ch_q   <= '0;
    end else begin
      base_addr_q <= base_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_addr_q  <= cur_addr_d;
      cur_cnt_q   <= cur_cnt_d;
      mode_q      <= mode_d;
      byte_ptr_q  <= byte_ptr_d;
      rd_data_q   <= rd_data_d;
      tc_status_q <= tc_status_d;
      xfer_ch_q   <= xfer_ch_d;
    end
  end

  assign rdData   = rd_data_q;
  assign tcStatus = tc_status_q;
  assign bytePtr  = byte_ptr_q;

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Directed bench for dma_channel_regfile: default 4x16 instance plus an 8-channel 24-bit one.
module tb_dma_channel_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        prog_en, wr_en, rd_en, reg_sel, clear_ptr, mode_wr;
  logic        xfer_start, xfer_step, xfer_end, status_rd;
  logic [1:0]  ch_sel, xfer_ch, mode_data;
  logic [7:0]  wr_data, rd_data;
  logic [15:0] addr_out;
  logic        tc;
  logic [3:0]  tc_status;
  logic [0:0]  byte_ptr;

  logic        wr_en2, rd_en2, clear_ptr2, zero2;
  logic [2:0]  ch_sel2, zero_ch2;
  logic [1:0]  zero_mode2;
  logic [7:0]  wr_data2, rd_data2;
  logic [23:0] addr_out2;
  logic        tc2;
  logic [7:0]  tc_status2;
  logic [1:0]  byte_ptr2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  dma_channel_regfile dut (
    .CLK(clk), .RESET(rst), .progEn(prog_en), .wrEn(wr_en), .rdEn(rd_en),
    .regSel(reg_sel), .chSel(ch_sel), .wrData(wr_data), .rdData(rd_data),
    .clearPtr(clear_ptr), .modeWr(mode_wr), .modeData(mode_data),
    .xferStart(xfer_start), .xferCh(xfer_ch), .xferStep(xfer_step), .xferEnd(xfer_end),
    .addrOut(addr_out), .tc(tc), .statusRd(status_rd), .tcStatus(tc_status),
    .bytePtr(byte_ptr)
  );

  dma_channel_regfile #(
    .CHANNELS(8), .ADDRESSWIDTH(24), .DATAWIDTH(8)
  ) dut24 (
    .CLK(clk), .RESET(rst), .progEn(1'b1), .wrEn(wr_en2), .rdEn(rd_en2),
    .regSel(zero2), .chSel(ch_sel2), .wrData(wr_data2), .rdData(rd_data2),
    .clearPtr(clear_ptr2), .modeWr(zero2), .modeData(zero_mode2),
    .xferStart(zero2), .xferCh(zero_ch2), .xferStep(zero2), .xferEnd(zero2),
    .addrOut(addr_out2), .tc(tc2), .statusRd(zero2), .tcStatus(tc_status2),
    .bytePtr(byte_ptr2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic sel, input logic [1:0] ch, input logic [7:0] d);
    reg_sel = sel; ch_sel = ch; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_byte(input logic sel, input logic [1:0] ch, output logic [7:0] d);
    reg_sel = sel; ch_sel = ch; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic clr();
    clear_ptr = 1'b1;
    tick();
    clear_ptr = 1'b0;
  endtask

  task automatic prog16(input logic sel, input logic [1:0] ch, input logic [15:0] v);
    clr();
    wr_byte(sel, ch, v[7:0]);
    wr_byte(sel, ch, v[15:8]);
  endtask

  task automatic read16(input logic sel, input logic [1:0] ch, output logic [15:0] v);
    logic [7:0] lo, hi;
    clr();
    rd_byte(sel, ch, lo);
    rd_byte(sel, ch, hi);
    v = {hi, lo};
  endtask

  task automatic set_mode(input logic [1:0] ch, input logic [1:0] m);
    ch_sel = ch; mode_data = m; mode_wr = 1'b1;
    tick();
    mode_wr = 1'b0;
  endtask

  task automatic start(input logic [1:0] ch);
    prog_en = 1'b0; xfer_ch = ch; xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic step();
    xfer_step = 1'b1;
    tick();
    xfer_step = 1'b0;
  endtask

  task automatic finish_xfer();
    xfer_end = 1'b1;
    tick();
    xfer_end = 1'b0;
    prog_en = 1'b1;
  endtask

  task automatic clear_status();
    status_rd = 1'b1;
    tick();
    status_rd = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0]  b;
    logic [23:0] v24, val24;

    rst = 1'b1; prog_en = 1'b1; wr_en = 0; rd_en = 0; reg_sel = 0; clear_ptr = 0;
    mode_wr = 0; xfer_start = 0; xfer_step = 0; xfer_end = 0; status_rd = 0;
    ch_sel = 0; xfer_ch = 0; mode_data = 0; wr_data = 0;
    wr_en2 = 0; rd_en2 = 0; clear_ptr2 = 0; zero2 = 0; ch_sel2 = 0; zero_ch2 = 0;
    zero_mode2 = 0; wr_data2 = 0;
    #12 rst = 1'b0;
    tick();

    check("rst_rddata", 32'(rd_data), 32'h0);
    check("rst_addrout", 32'(addr_out), 32'h0);
    check("rst_tc", 32'(tc), 32'h0);
    check("rst_tcstatus", 32'(tc_status), 32'h0);
    check("rst_byteptr", 32'(byte_ptr), 32'h0);

    // Byte-wise programming and readback of channel 2 address.
    clr();
    wr_byte(1'b0, 2'd2, 8'h34);
    wr_byte(1'b0, 2'd2, 8'h12);
    check("prog_ptr_wrap", 32'(byte_ptr), 32'h0);
    rd_byte(1'b0, 2'd2, b);
    check("rd_lo", 32'(b), 32'h34);
    rd_byte(1'b0, 2'd2, b);
    check("rd_hi", 32'(b), 32'h12);
    check("rd_ptr_wrap", 32'(byte_ptr), 32'h0);

    // Write beats read; clearPtr beats the advance but the write still lands.
    reg_sel = 0; ch_sel = 2; wr_data = 8'h77; wr_en = 1; rd_en = 1;
    tick();
    wr_en = 0; rd_en = 0;
    check("wr_rd_hold", 32'(rd_data), 32'h12);
    check("wr_rd_ptr", 32'(byte_ptr), 32'h1);
    wr_data = 8'h56; wr_en = 1; clear_ptr = 1;
    tick();
    wr_en = 0; clear_ptr = 0;
    check("clr_wr_ptr", 32'(byte_ptr), 32'h0);
    read16(1'b0, 2'd2, v);
    check("clr_wr_val", 32'(v), 32'h5677);

    // Plain incrementing transfer on channel 1 with TC.
    set_mode(2'd1, 2'b00);
    prog16(1'b0, 2'd1, 16'h1000);
    prog16(1'b1, 2'd1, 16'h0002);
    start(2'd1);
    check("x0_start_addr", 32'(addr_out), 32'h1000);
    step();
    check("x0_addr1", 32'(addr_out), 32'h1001);
    check("x0_tc1", 32'(tc), 32'h0);
    step();
    check("x0_addr2", 32'(addr_out), 32'h1002);
    check("x0_tc2", 32'(tc), 32'h0);
    step();
    check("x0_addr3", 32'(addr_out), 32'h1003);
    check("x0_tc3", 32'(tc), 32'h1);
    check("x0_status", 32'(tc_status), 32'h2);
    finish_xfer();
    check("x0_tc_pulse", 32'(tc), 32'h0);
    read16(1'b0, 2'd1, v);
    check("x0_cur_addr", 32'(v), 32'h1003);
    read16(1'b1, 2'd1, v);
    check("x0_cur_cnt", 32'(v), 32'hFFFF);
    clear_status();
    check("x0_status_clr", 32'(tc_status), 32'h0);

    // Autoinitialize reloads current from base after TC.
    set_mode(2'd1, 2'b01);
    prog16(1'b0, 2'd1, 16'h1000);
    prog16(1'b1, 2'd1, 16'h0002);
    start(2'd1);
    step(); step(); step();
    check("ai_tc3", 32'(tc), 32'h1);
    finish_xfer();
    read16(1'b0, 2'd1, v);
    check("ai_cur_addr", 32'(v), 32'h1000);
    read16(1'b1, 2'd1, v);
    check("ai_cur_cnt", 32'(v), 32'h0002);
    check("ai_status_sticky", 32'(tc_status), 32'h2);
    clear_status();
    check("ai_status_clr", 32'(tc_status), 32'h0);

    // Decrement from zero wraps the address and hits TC at once.
    set_mode(2'd3, 2'b10);
    prog16(1'b0, 2'd3, 16'h0000);
    prog16(1'b1, 2'd3, 16'h0000);
    start(2'd3);
    step();
    check("dec_addr_wrap", 32'(addr_out), 32'hFFFF);
    check("dec_tc", 32'(tc), 32'h1);
    check("dec_status", 32'(tc_status), 32'h8);
    finish_xfer();
    read16(1'b0, 2'd3, v);
    check("dec_cur_addr", 32'(v), 32'hFFFF);
    read16(1'b1, 2'd3, v);
    check("dec_cur_cnt", 32'(v), 32'hFFFF);
    clear_status();

    // Byte pointer control and writes ignored outside programming.
    prog16(1'b1, 2'd0, 16'h2211);
    clr();
    wr_byte(1'b1, 2'd0, 8'h55);
    check("bp_adv", 32'(byte_ptr), 32'h1);
    clr();
    check("bp_clr", 32'(byte_ptr), 32'h0);
    wr_byte(1'b1, 2'd0, 8'hAB);
    read16(1'b1, 2'd0, v);
    check("bp_lo_only", 32'(v), 32'h22AB);
    clr();
    prog_en = 1'b0;
    wr_byte(1'b1, 2'd0, 8'h99);
    check("bp_noprog_ptr", 32'(byte_ptr), 32'h0);
    prog_en = 1'b1;
    read16(1'b1, 2'd0, v);
    check("bp_noprog_val", 32'(v), 32'h22AB);

    // Start beats a same-cycle step; TC beats a same-cycle status clear.
    set_mode(2'd1, 2'b00);
    prog16(1'b0, 2'd1, 16'h2000);
    prog16(1'b1, 2'd1, 16'h0000);
    prog_en = 0; xfer_ch = 1; xfer_start = 1; xfer_step = 1;
    tick();
    xfer_start = 0; xfer_step = 0;
    check("start_wins_addr", 32'(addr_out), 32'h2000);
    check("start_wins_tc", 32'(tc), 32'h0);
    xfer_step = 1; status_rd = 1;
    tick();
    xfer_step = 0; status_rd = 0;
    check("tc_beats_clr", 32'(tc_status), 32'h2);
    xfer_step = 1; xfer_end = 1;
    tick();
    xfer_step = 0; xfer_end = 0; prog_en = 1;
    read16(1'b0, 2'd1, v);
    check("step_end_addr", 32'(v), 32'h2002);
    clear_status();

    // Asynchronous reset between edges during a transfer.
    prog16(1'b0, 2'd0, 16'h4000);
    prog16(1'b1, 2'd0, 16'h0005);
    rd_byte(1'b0, 2'd0, b);
    start(2'd0);
    step();
    check("ar_pre_addr", 32'(addr_out), 32'h4001);
    #3 rst = 1'b1;
    #1;
    check("ar_addrout", 32'(addr_out), 32'h0);
    check("ar_rddata", 32'(rd_data), 32'h0);
    check("ar_byteptr", 32'(byte_ptr), 32'h0);
    check("ar_tc", 32'(tc), 32'h0);
    check("ar_tcstatus", 32'(tc_status), 32'h0);
    #2 rst = 1'b0;
    prog_en = 1'b1;
    tick();
    read16(1'b0, 2'd0, v);
    check("ar_cur_addr", 32'(v), 32'h0);
    read16(1'b1, 2'd0, v);
    check("ar_cur_cnt", 32'(v), 32'h0);

    // Three-byte programming on the 8-channel, 24-bit instance.
    val24 = 24'hABCDEF;
    ch_sel2 = 3'd5;
    clear_ptr2 = 1;
    tick();
    clear_ptr2 = 0;
    for (int i = 0; i < 3; i++) begin
      wr_data2 = val24[8*i +: 8];
      wr_en2 = 1;
      tick();
      wr_en2 = 0;
      check("w24_ptr", 32'(byte_ptr2), 32'((i + 1) % 3));
    end
    v24 = '0;
    for (int i = 0; i < 3; i++) begin
      rd_en2 = 1;
      tick();
      rd_en2 = 0;
      v24[8*i +: 8] = rd_data2;
    end
    check("w24_roundtrip", 32'(v24), 32'hABCDEF);
    check("w24_ptr_end", 32'(byte_ptr2), 32'h0);
    ch_sel2 = 3'd4;
    rd_en2 = 1;
    tick();
    rd_en2 = 0;
    check("w24_other_ch", 32'(rd_data2), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
